fetch: RTL

//   Instruction-fetch stage, directly upstream of decode; supplies command and out_now_pc to it.

---
 rtl/fetch.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/fetch.sv
// rtl/fetch.sv - instruction fetch stage: fetch PC, in-order imem requests, prefetch FIFO, redirect/stop
// Optional feature macro FETCH_STALL_CNT_EN adds the fetch_stall_cnt empty-FIFO cycle counter.
module fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 4,
  parameter logic [31:0] NOP_INSN  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stop,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] command,
  output logic [31:0] out_now_pc,
  output logic        out_valid
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [31:0] fetch_stall_cnt
`endif
);

  localparam int unsigned AW = $clog2(BUF_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(BUF_DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   push_pc_q, push_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   command_q, command_d;
  logic [31:0]   now_pc_q, now_pc_d;
  logic          valid_q, valid_d;

  logic [31:0]   word_mem [BUF_DEPTH];
  logic [31:0]   pc_mem   [BUF_DEPTH];

  logic [CW:0]   in_use;
  logic          grant;
  logic          push;
  logic          pop;
  logic [31:0]   target_pc;

  // Outstanding requests reserve a FIFO slot, so an ack can never find the FIFO full.
  assign in_use    = {1'b0, outstanding_q} + {1'b0, count_q};
  assign imem_req  = !redirect && (in_use < DEPTH_W);
  assign imem_addr = fetch_pc_q;
  assign grant     = imem_req && imem_gnt;
  assign push      = imem_ack && (drop_cnt_q == '0) && !redirect;
  assign pop       = !redirect && !stop && (count_q != '0);
  assign target_pc = redirect_pc & 32'hFFFF_FFFC;

  assign command    = command_q;
  assign out_now_pc = now_pc_q;
  assign out_valid  = valid_q;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    push_pc_d     = push_pc_q;
    outstanding_d = outstanding_q + CW'(grant) - CW'(imem_ack);
    drop_cnt_d    = drop_cnt_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    command_d     = command_q;
    now_pc_d      = now_pc_q;
    valid_d       = valid_q;

    if (redirect) begin
      // Everything still in flight belongs to the abandoned path.
      fetch_pc_d = target_pc;
      push_pc_d  = target_pc;
      drop_cnt_d = outstanding_q - CW'(imem_ack);
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (grant) fetch_pc_d = fetch_pc_q + 32'd4;
      if (imem_ack && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - 1'b1;
      if (push) begin
        push_pc_d = push_pc_q + 32'd4;
        wr_ptr_d  = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
    end

    if (redirect) begin
      command_d = NOP_INSN;
      valid_d   = 1'b0;
    end else if (!stop) begin
      if (pop) begin
        command_d = word_mem[rd_ptr_q];
        now_pc_d  = pc_mem[rd_ptr_q];
        valid_d   = 1'b1;
      end else begin
        command_d = NOP_INSN;
        valid_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q    <= RESET_PC;
      push_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      command_q     <= NOP_INSN;
      now_pc_q      <= RESET_PC;
      valid_q       <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      push_pc_q     <= push_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      command_q     <= command_d;
      now_pc_q      <= now_pc_d;
      valid_q       <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      word_mem[wr_ptr_q] <= imem_rdata;
      pc_mem[wr_ptr_q]   <= push_pc_q;
    end
  end

`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (!stop && !redirect && (count_q == '0)) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign fetch_stall_cnt = stall_q;
`endif

endmodule
